alu_mdu: RTL
============

Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Executes all base integer ops plus RISC-V M-extension multiply/divide/remainder.
- Uses valid/ready handshakes on both the operand and result sides.
- Sits in the execute stage; the control unit stalls issue while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from in_2[SHW-1:0]; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an op this cycle.
- in_1  input  WIDTH  operand A.
- in_2  input  WIDTH  operand B.
- operation  input  5  op code (see Behaviour).
- out_valid  output  1  result held on out.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- err  output  1  qualifies out; high when the accepted op code was undefined.
- busy  output  1  high in BUSY state.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, err=0, busy=0. Reset mid-operation aborts the op; no result is produced.
- Op codes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL.
  - 7 SRA: arithmetic right shift, sign-filled.
  - 8 SLT, 9 SLTU, 10 EQL, 11 NEQ, 12 GTE (signed), 13 GTEU.
  - 16 MUL (low half), 17 MULH (s×s high), 18 MULHSU (s×u high), 19 MULHU (u×u high).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: out=0, err=1, single-cycle path.
- Shifts use only in_2[SHW-1:0]. Compares return 1 or 0, zero-extended.
- State machine:
  - Acceptance happens on a cycle with in_valid & in_ready. Operands are registered; later changes on in_* are ignored.
  - IDLE: in_ready=1. A basic/undefined op goes to DONE with the result registered (latency 1: out_valid is high the cycle after acceptance). A mul/div op goes to BUSY with count=0.
  - BUSY: in_ready=0, busy=1.
    - Multiply is shift-add on magnitudes, one bit per cycle, 2·WIDTH-bit product.
    - Divide is restoring, one quotient bit per cycle, on magnitudes.
    - Sign fix-up is applied on the final step.
    - After exactly WIDTH cycles go to DONE. Total latency is WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1; out/err are held stable until out_ready. When out_valid & out_ready, go to IDLE.
  - in_ready stays 0 in DONE. No new op is accepted in the same cycle a result is consumed.
- Division special cases resolve in 1 cycle, skipping BUSY:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give in_1.
  - Signed overflow (in_1=min, in_2=-1): DIV gives min; REM gives 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Optional Feature:
- Macro: ALU_MDU_FAST_MUL_EN.
- Defined: ops 16–19 use a single combinational 2·WIDTH multiply and go IDLE→DONE with latency 1, like the basic ops. Division is unchanged.
- Undefined: iterative multiply, WIDTH+1 cycle latency.
- Results are bit-identical in both builds.

Test Plan:
- WIDTH=32, ADD 0xFFFFFFFF+1 -> out=0, out_valid one cycle after accept. SRA 0x80000000 by 4 -> 0xF8000000. SLT -1,1 -> 1. SLTU -1,1 -> 0.
- MULH 0x80000000×0x80000000 -> 0x40000000 after 33 cycles. MUL 7×-3 -> 0xFFFFFFEB. MULHU 0xFFFFFFFF×2 -> 1.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each takes 33 cycles.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM of the same -> 0. Each takes 1 cycle.
- Backpressure: hold out_ready=0 ten cycles in DONE -> out stable, in_ready=0; a driven in_valid is not accepted. Undefined op 15 -> err=1, out=0.
- Assert rst mid-DIVU (cycle 10) -> next cycle in_ready=1, out_valid=0. A subsequent ADD 2+3 returns 5 normally.

Source files
------------

// File: rtl/alu_mdu_if.sv
// ---------------------------------------------------------------------------
// alu_mdu_if
// Operand/result handshake bundle for the alu_mdu execute-stage unit.
//
// Signals:
//   in_valid   operand/op presented by the issuing side
//   in_ready   unit can accept an op this cycle
//   in_1/in_2  operands A and B (WIDTH bits)
//   operation  5-bit op code
//   out_valid  result held on out
//   out_ready  consumer takes the result
//   out        result (WIDTH bits)
//   err        qualifies out: the accepted op code was undefined
//   busy       unit is iterating a multiply/divide
//
// Modports:
//   master  issuing side (drives operands, accepts results)
//   slave   the alu_mdu itself
// ---------------------------------------------------------------------------
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic [4:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, in_1, in_2, operation, out_ready,
        input  in_ready, out_valid, out, err, busy
    );

    modport slave (
        input  in_valid, in_1, in_2, operation, out_ready,
        output in_ready, out_valid, out, err, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// ---------------------------------------------------------------------------
// alu_mdu
// Multi-cycle ALU plus RISC-V M-extension multiply/divide/remainder unit.
// Basic ops, undefined ops and divide special cases (divide by zero, signed
// overflow) complete one cycle after acceptance. Multiply and divide iterate
// one bit per cycle on operand magnitudes, with the sign fix-up folded into
// the last step, giving WIDTH+1 cycles from acceptance to out_valid.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset (aborts any op in flight)
//   bus   alu_mdu_if.slave: in_valid/in_ready/in_1/in_2/operation,
//         out_valid/out_ready/out/err, busy
//
// Build option:
//   ALU_MDU_FAST_MUL_EN  when defined, MUL/MULH/MULHSU/MULHU use a single
//                        combinational 2*WIDTH multiply and complete in one
//                        cycle; division stays iterative. Results are
//                        identical in both builds.
// ---------------------------------------------------------------------------
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_mdu_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_XOR    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_EQL    = 5'd10;
    localparam logic [4:0] OP_NEQ    = 5'd11;
    localparam logic [4:0] OP_GTE    = 5'd12;
    localparam logic [4:0] OP_GTEU   = 5'd13;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered operation context
    logic [4:0]         r_op;
    logic               r_neg_p;     // product / quotient must be negated
    logic               r_a_neg;     // remainder must be negated
    logic [WIDTH-1:0]   r_mag;       // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] r_acc;       // {hi, lo}: product or {remainder, dividend/quotient}
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic               r_err;

    // Acceptance-side decode
    logic [4:0]       w_op;
    logic [SHW-1:0]   w_shamt;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_iter;
    logic             w_sa;
    logic             w_sb;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_quick_res;
    logic             w_quick_err;

    // Iteration datapath
    logic               w_r_is_mul;
    logic               w_last;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_fix;

    assign w_op     = bus.operation;
    assign w_shamt  = bus.in_2[SHW-1:0];
    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_is_mul = (w_op[4:2] == 3'b100);
    assign w_is_div = (w_op[4:2] == 3'b101);

    assign w_div_zero = (bus.in_2 == '0);
    // Only the signed forms can overflow: MIN / -1
    assign w_div_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (bus.in_1 == MIN_S) && (bus.in_2 == '1);

`ifdef ALU_MDU_FAST_MUL_EN
    assign w_iter = w_is_div && !w_div_zero && !w_div_ovf;
`else
    assign w_iter = (w_is_div && !w_div_zero && !w_div_ovf) || w_is_mul;
`endif

    // Operand A is signed for MUL/MULH/MULHSU/DIV/REM; B for MUL/MULH/DIV/REM.
    // MUL (low half) is sign-agnostic, so treating it as signed is harmless.
    assign w_sa = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                  (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_sb = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                  (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_a_neg = w_sa && bus.in_1[WIDTH-1];
    assign w_b_neg = w_sb && bus.in_2[WIDTH-1];
    // -MIN wraps to MIN, which read unsigned is the correct magnitude
    assign w_mag_a = w_a_neg ? (~bus.in_1 + 1'b1) : bus.in_1;
    assign w_mag_b = w_b_neg ? (~bus.in_2 + 1'b1) : bus.in_2;

`ifdef ALU_MDU_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = $signed({{WIDTH{w_a_neg}}, bus.in_1}) *
                         $signed({{WIDTH{w_b_neg}}, bus.in_2});
`endif

    function automatic logic [WIDTH-1:0] f_mul_fix(input logic [2*WIDTH-1:0] p,
                                                   input logic neg,
                                                   input logic lo);
        logic [2*WIDTH-1:0] s;
        s = neg ? (~p + 1'b1) : p;
        return lo ? s[WIDTH-1:0] : s[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] f_div_fix(input logic [2*WIDTH-1:0] acc,
                                                   input logic qneg,
                                                   input logic rneg,
                                                   input logic is_rem);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        q = acc[WIDTH-1:0];
        r = acc[2*WIDTH-1:WIDTH];
        if (is_rem) begin
            return rneg ? (~r + 1'b1) : r;
        end
        return qneg ? (~q + 1'b1) : q;
    endfunction

    // Single-cycle results: basic ops, undefined codes, divide special cases
    always_comb begin
        w_quick_res = '0;
        w_quick_err = 1'b0;
        case (w_op)
            OP_ADD:  w_quick_res = bus.in_1 + bus.in_2;
            OP_SUB:  w_quick_res = bus.in_1 - bus.in_2;
            OP_XOR:  w_quick_res = bus.in_1 ^ bus.in_2;
            OP_OR:   w_quick_res = bus.in_1 | bus.in_2;
            OP_AND:  w_quick_res = bus.in_1 & bus.in_2;
            OP_SLL:  w_quick_res = bus.in_1 << w_shamt;
            OP_SRL:  w_quick_res = bus.in_1 >> w_shamt;
            OP_SRA:  w_quick_res = $signed(bus.in_1) >>> w_shamt;
            OP_SLT:  w_quick_res = WIDTH'($signed(bus.in_1) < $signed(bus.in_2));
            OP_SLTU: w_quick_res = WIDTH'(bus.in_1 < bus.in_2);
            OP_EQL:  w_quick_res = WIDTH'(bus.in_1 == bus.in_2);
            OP_NEQ:  w_quick_res = WIDTH'(bus.in_1 != bus.in_2);
            OP_GTE:  w_quick_res = WIDTH'($signed(bus.in_1) >= $signed(bus.in_2));
            OP_GTEU: w_quick_res = WIDTH'(bus.in_1 >= bus.in_2);
`ifdef ALU_MDU_FAST_MUL_EN
            OP_MUL:  w_quick_res = w_fast_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:
                     w_quick_res = w_fast_prod[2*WIDTH-1:WIDTH];
`else
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:
                     w_quick_res = '0;
`endif
            OP_DIV, OP_DIVU: begin
                if (w_div_zero) begin
                    w_quick_res = '1;
                end else if (w_div_ovf) begin
                    w_quick_res = MIN_S;
                end
            end
            OP_REM, OP_REMU: begin
                if (w_div_zero) begin
                    w_quick_res = bus.in_1;
                end
            end
            default: w_quick_err = 1'b1;
        endcase
    end

    // One iteration step. Multiply: shift-add with the multiplier in the low
    // half shifting out as the product shifts in. Divide: restoring, the
    // dividend in the low half shifts into the remainder as quotient bits
    // shift in from the right.
    assign w_r_is_mul = (r_op[4:2] == 3'b100);
    assign w_last     = (r_cnt == SHW'(WIDTH-1));

    always_comb begin
        w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);
        w_rsh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff = w_rsh - {1'b0, r_mag};
        if (w_r_is_mul) begin
            w_step = {w_add, r_acc[WIDTH-1:1]};
        end else if (w_diff[WIDTH]) begin
            w_step = {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    assign w_fix = w_r_is_mul ? f_mul_fix(w_step, r_neg_p, r_op == OP_MUL)
                              : f_div_fix(w_step, r_neg_p, r_a_neg, r_op[1]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_iter ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.out = r_out;
    assign bus.err = r_err;

    // Datapath registers: operands captured on acceptance, stepped in BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_neg_p <= w_a_neg ^ w_b_neg;
                        r_a_neg <= w_a_neg;
                        r_cnt   <= '0;
                        if (w_is_mul) begin
                            r_mag <= w_mag_a;
                            r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                        end else begin
                            r_mag <= w_mag_b;
                            r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                        end
                        if (!w_iter) begin
                            r_out <= w_quick_res;
                            r_err <= w_quick_err;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + SHW'(1);
                    if (w_last) begin
                        r_out <= w_fix;
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
